// File: rtl/hamming_secded_codec.sv
// Serial Hamming SECDED encoder/decoder: scans one codeword position per cycle.
// Build with HAMMING_CORRECT_EN defined to correct single errors; default is detect-only.
//
// state  | meaning
// IDLE   | waiting for start, last results held
// LOAD   | build working vector from registered operand
// SCAN   | accumulate syndrome and overall parity, one bit per cycle
// FINISH | place parity bits (encode) or classify error (decode)
// DONE   | results valid, wait for start to drop
module hamming_secded_codec #(
    parameter int DW = 11,
    parameter int PW = 4,
    localparam int CW = DW + PW + 1,
    localparam int SW = $clog2(CW)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          mode_in,
    input  logic [DW-1:0] data_in,
    input  logic [CW-1:0] code_in,
    output logic          busy_out,
    output logic          ready_out,
    output logic [CW-1:0] code_out,
    output logic [DW-1:0] data_out,
    output logic          err_single_out,
    output logic          err_double_out,
    output logic [SW-1:0] err_pos_out
);

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, FINISH, DONE} state_t;

    function automatic bit is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    function automatic int log2i(input int p);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) if ((1 << k) == p) r = k;
        return r;
    endfunction

    // index of the data bit stored at codeword position p
    function automatic int didx(input int p);
        int n;
        n = 0;
        for (int q = 3; q < p; q++) if (!is_pow2(q)) n++;
        return n;
    endfunction

    function automatic int dpos(input int i);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int q = 3; q < CW; q++) begin
            if (!is_pow2(q)) begin
                if (n == i) r = q;
                n++;
            end
        end
        return r;
    endfunction

    if (DW < 4 || DW > 26) begin : g_dw_chk
        $error("hamming_secded_codec: DW must be in 4..26");
    end
    if ((1 << PW) < CW) begin : g_pw_chk
        $error("hamming_secded_codec: PW too small, need 2**PW >= DW+PW+1");
    end

    state_t        state, state_nxt;
    logic          mode_r;
    logic [DW-1:0] data_r;
    logic [CW-1:0] code_r;
    logic [CW-1:0] work;
    logic [PW-1:0] syn;
    logic          ovr;
    logic [SW-1:0] idx;

    logic [CW-1:0] scat;
    logic [CW-1:1] enc_hi;
    logic [CW-1:0] flip;
    logic [CW-1:0] corrected;
    logic [DW-1:0] dec_data;
    logic          par;
    logic          fin_single;
    logic          fin_double;
    logic [SW-1:0] fin_pos;

    assign scat[0] = 1'b0;
    for (genvar p = 1; p < CW; p++) begin : g_pos
        if (is_pow2(p)) begin : g_par
            assign scat[p]   = 1'b0;
            assign enc_hi[p] = syn[log2i(p)];
        end else if (didx(p) < DW) begin : g_dat
            assign scat[p]   = data_r[didx(p)];
            assign enc_hi[p] = work[p];
        end else begin : g_pad
            assign scat[p]   = 1'b0;
            assign enc_hi[p] = 1'b0;
        end
    end

    for (genvar i = 0; i < DW; i++) begin : g_gat
        assign dec_data[i] = corrected[dpos(i)];
    end

    assign busy_out = (state == LOAD) || (state == SCAN) || (state == FINISH);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SCAN;
            SCAN:    if (idx == SW'(CW - 1)) state_nxt = FINISH;
            FINISH:  state_nxt = DONE;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // decode classification; overall parity compares scanned bits against stored bit 0
    always_comb begin
        par        = ovr ^ work[0];
        fin_single = 1'b0;
        fin_double = 1'b0;
        fin_pos    = '0;
        if (par && syn == '0) begin
            fin_single = 1'b1;
        end else if (par && ({1'b0, syn} < (PW + 1)'(CW))) begin
            fin_single = 1'b1;
            fin_pos    = SW'(syn);
        end else if (par || syn != '0) begin
            fin_double = 1'b1;
        end
`ifdef HAMMING_CORRECT_EN
        flip = fin_single ? (CW'(1) << fin_pos) : '0;
`else
        flip = '0;
`endif
        corrected = work ^ flip;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r         <= 1'b0;
            data_r         <= '0;
            code_r         <= '0;
            work           <= '0;
            syn            <= '0;
            ovr            <= 1'b0;
            idx            <= '0;
            ready_out      <= 1'b0;
            code_out       <= '0;
            data_out       <= '0;
            err_single_out <= 1'b0;
            err_double_out <= 1'b0;
            err_pos_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode_in;
                        data_r <= data_in;
                        code_r <= code_in;
                    end
                end
                LOAD: begin
                    ready_out <= 1'b0;
                    work      <= mode_r ? code_r : scat;
                    syn       <= '0;
                    ovr       <= 1'b0;
                    idx       <= SW'(1);
                end
                SCAN: begin
                    if (work[idx]) syn <= syn ^ PW'(idx);
                    ovr <= ovr ^ work[idx];
                    if (idx != SW'(CW - 1)) idx <= idx + SW'(1);
                end
                FINISH: begin
                    ready_out <= 1'b1;
                    if (mode_r) begin
                        code_out       <= corrected;
                        data_out       <= dec_data;
                        err_single_out <= fin_single;
                        err_double_out <= fin_double;
                        err_pos_out    <= fin_pos;
                    end else begin
                        code_out       <= {enc_hi, ^enc_hi};
                        data_out       <= data_r;
                        err_single_out <= 1'b0;
                        err_double_out <= 1'b0;
                        err_pos_out    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Scoreboard bench for hamming_secded_codec (DW=11 main instance, DW=8 side instance).
module tb_hamming_secded_codec;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        mode_in;
    logic [10:0] data_in;
    logic [15:0] code_in;
    logic        busy_out, ready_out, err_single_out, err_double_out;
    logic [15:0] code_out;
    logic [10:0] data_out;
    logic [3:0]  err_pos_out;

    logic        start8, mode8;
    logic [7:0]  data8;
    logic [12:0] code8;
    logic        busy8, ready8, es8, ed8;
    logic [12:0] code_o8;
    logic [7:0]  data_o8;
    logic [3:0]  pos8;

    hamming_secded_codec #(.DW(11), .PW(4)) u_dut (
        .clock(clock), .reset(reset), .start(start), .mode_in(mode_in),
        .data_in(data_in), .code_in(code_in), .busy_out(busy_out),
        .ready_out(ready_out), .code_out(code_out), .data_out(data_out),
        .err_single_out(err_single_out), .err_double_out(err_double_out),
        .err_pos_out(err_pos_out)
    );

    hamming_secded_codec #(.DW(8), .PW(4)) u_dut8 (
        .clock(clock), .reset(reset), .start(start8), .mode_in(mode8),
        .data_in(data8), .code_in(code8), .busy_out(busy8),
        .ready_out(ready8), .code_out(code_o8), .data_out(data_o8),
        .err_single_out(es8), .err_double_out(ed8), .err_pos_out(pos8)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [15:0] code;
        logic [10:0] data;
        logic        es;
        logic        ed;
        logic [3:0]  pos;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];
    exp_t me, me8;
    int   total = 0;
    int   bad = 0;
    logic ready_q = 1'b0;
    logic ready8_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp_v);
        end
    endtask

    // monitors: one pop per rising ready
    always @(negedge clock) begin
        if (ready_out && !ready_q) begin
            chk("ready_has_expect", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                me = q.pop_front();
                chk({me.name, "_code"}, 32'(code_out), 32'(me.code));
                chk({me.name, "_data"}, 32'(data_out), 32'(me.data));
                chk({me.name, "_single"}, 32'(err_single_out), 32'(me.es));
                chk({me.name, "_double"}, 32'(err_double_out), 32'(me.ed));
                chk({me.name, "_pos"}, 32'(err_pos_out), 32'(me.pos));
                chk({me.name, "_latency"}, 32'(cyc - me.acc), 32'(me.lat));
            end
        end
        ready_q = ready_out;
        if (ready8 && !ready8_q) begin
            chk("ready8_has_expect", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                me8 = q8.pop_front();
                chk({me8.name, "_code"}, 32'(code_o8), 32'(me8.code));
                chk({me8.name, "_data"}, 32'(data_o8), 32'(me8.data));
                chk({me8.name, "_single"}, 32'(es8), 32'(me8.es));
                chk({me8.name, "_double"}, 32'(ed8), 32'(me8.ed));
                chk({me8.name, "_pos"}, 32'(pos8), 32'(me8.pos));
                chk({me8.name, "_latency"}, 32'(cyc - me8.acc), 32'(me8.lat));
            end
        end
        ready8_q = ready8;
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || q8.size() != 0) && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_drain"}, 32'(q.size() + q8.size()), 32'd0);
        q.delete();
        q8.delete();
        @(negedge clock);
    endtask

    task automatic run_op(input string name, input logic mode, input logic [10:0] d,
                          input logic [15:0] c, input logic [15:0] ec, input logic [10:0] ed,
                          input logic es, input logic edb, input logic [3:0] ep);
        exp_t e;
        @(negedge clock);
        mode_in = mode;
        data_in = d;
        code_in = c;
        start   = 1'b1;
        @(posedge clock);
        #1;
        e.name = name; e.code = ec; e.data = ed; e.es = es; e.ed = edb;
        e.pos = ep; e.lat = 17; e.acc = cyc;
        q.push_back(e);
        chk({name, "_busy"}, 32'(busy_out), 32'd1);
        start   = 1'b0;
        mode_in = ~mode;
        data_in = ~d;
        code_in = ~c;
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(name);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; start = 1'b1; mode_in = 1'b0; data_in = 11'h001; code_in = '0;
        start8 = 1'b0; mode8 = 1'b0; data8 = '0; code8 = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd0);
        chk("rst_code", 32'(code_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_flags", 32'({err_single_out, err_double_out}), 32'd0);
        chk("rst_pos", 32'(err_pos_out), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("rst_start_ignored", 32'(busy_out), 32'd0);

        run_op("enc001", 1'b0, 11'h001, 16'h0000, 16'h000F, 11'h001, 1'b0, 1'b0, 4'd0);
        run_op("dec000F", 1'b1, 11'h000, 16'h000F, 16'h000F, 11'h001, 1'b0, 1'b0, 4'd0);
`ifdef HAMMING_CORRECT_EN
        run_op("dec002F", 1'b1, 11'h000, 16'h002F, 16'h000F, 11'h001, 1'b1, 1'b0, 4'd5);
        run_op("dec000E", 1'b1, 11'h000, 16'h000E, 16'h000F, 11'h001, 1'b1, 1'b0, 4'd0);
        run_op("dec8317", 1'b1, 11'h000, 16'h8317, 16'h8117, 11'h400, 1'b1, 1'b0, 4'd9);
`else
        run_op("dec002F", 1'b1, 11'h000, 16'h002F, 16'h002F, 11'h003, 1'b1, 1'b0, 4'd5);
        run_op("dec000E", 1'b1, 11'h000, 16'h000E, 16'h000E, 11'h001, 1'b1, 1'b0, 4'd0);
        run_op("dec8317", 1'b1, 11'h000, 16'h8317, 16'h8317, 11'h410, 1'b1, 1'b0, 4'd9);
`endif
        run_op("dec003F", 1'b1, 11'h000, 16'h003F, 16'h003F, 11'h003, 1'b0, 1'b1, 4'd0);
        run_op("enc7FF", 1'b0, 11'h7FF, 16'h0000, 16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);
        run_op("enc400", 1'b0, 11'h400, 16'h0000, 16'h8117, 11'h400, 1'b0, 1'b0, 4'd0);

        // start held through DONE must yield exactly one result
        @(negedge clock);
        mode_in = 1'b0; data_in = 11'h001; start = 1'b1;
        @(posedge clock);
        #1;
        e.name = "held"; e.code = 16'h000F; e.data = 11'h001; e.es = 1'b0; e.ed = 1'b0;
        e.pos = 4'd0; e.lat = 17; e.acc = cyc;
        q.push_back(e);
        repeat (25) @(negedge clock);
        chk("held_one_result", 32'(q.size()), 32'd0);
        chk("held_ready", 32'(ready_out), 32'd1);
        chk("held_not_busy", 32'(busy_out), 32'd0);
        start = 1'b0;
        repeat (5) @(negedge clock);
        chk("held_idle_ready", 32'(ready_out), 32'd1);
        chk("held_idle_code", 32'(code_out), 32'h000F);

        // reset in the middle of SCAN
        @(negedge clock);
        mode_in = 1'b0; data_in = 11'h7FF; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clock);
        chk("mid_busy_pre", 32'(busy_out), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_busy", 32'(busy_out), 32'd0);
        chk("mid_ready", 32'(ready_out), 32'd0);
        chk("mid_code", 32'(code_out), 32'd0);
        chk("mid_data", 32'(data_out), 32'd0);
        chk("mid_flags", 32'({err_single_out, err_double_out}), 32'd0);
        chk("mid_pos", 32'(err_pos_out), 32'd0);
        repeat (20) @(negedge clock);
        chk("mid_no_result", 32'(ready_out), 32'd0);
        run_op("enc001_again", 1'b0, 11'h001, 16'h0000, 16'h000F, 11'h001, 1'b0, 1'b0, 4'd0);

        // DW=8: syndrome 15 beyond codeword length is a double error
        @(negedge clock);
        mode8 = 1'b1; code8 = 13'h1009; start8 = 1'b1;
        @(posedge clock);
        #1;
        e.name = "d8_s15"; e.code = 16'h1009; e.data = 11'h081; e.es = 1'b0; e.ed = 1'b1;
        e.pos = 4'd0; e.lat = 14; e.acc = cyc;
        q8.push_back(e);
        start8 = 1'b0;
        wait_done("d8_s15");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hamming_secded_codec.md
HAMMING_SECDED_CODEC -- requirements
Module: hamming_secded_codec

Interface
REQ-001 Parameter DW, default 11: data word width, legal range 4..26.
REQ-002 Parameter PW, default 4: Hamming parity count; SHALL satisfy 2^PW >= DW+PW+1, else elaboration error.
REQ-003 Derived CW = DW+PW+1 (default 16): codeword width including overall parity bit; SW = clog2(CW).
REQ-004 clock  in  1: single clock, all state on rising edge.
REQ-005 reset  in  1: synchronous, active-high.
REQ-006 start  in  1: request; accepted only in IDLE.
REQ-007 mode_in  in  1: 0 = encode, 1 = decode.
REQ-008 data_in  in  DW: encode operand.
REQ-009 code_in  in  CW: decode operand.
REQ-010 busy_out  out  1: high from LOAD through FINISH.
REQ-011 ready_out  out  1: result valid.
REQ-012 code_out  out  CW: encoded word (encode) or corrected codeword (decode).
REQ-013 data_out  out  DW: extracted data (decode); echo of data_in (encode).
REQ-014 err_single_out / err_double_out  out  1 each: decode status; 0 in encode.
REQ-015 err_pos_out  out  SW: bit index of single error; 0 otherwise.

Function
REQ-016 Codeword layout: bit 0 = overall parity; bit 2^k = parity k (k=0..PW-1); remaining bits 3,5,6,7,9... = data bits 0..DW-1 ascending.
REQ-017 FSM states IDLE, LOAD, SCAN, FINISH, DONE; reset enters IDLE.
REQ-018 IDLE: start=1 -> LOAD; mode_in, data_in, code_in registered at that edge; later input changes ignored.
REQ-019 LOAD: ready_out cleared; working vector built (encode: data scattered, parity bits 0; decode: code_in copy); syndrome=0, index p=1; -> SCAN.
REQ-020 SCAN: one position per cycle, p=1..CW-1; if bit p set, syndrome ^= p; overall ^= bit p; after p=CW-1 -> FINISH.
REQ-021 FINISH encode: bit 2^k = syndrome[k]; bit 0 = XOR of final bits 1..CW-1; -> DONE.
REQ-022 FINISH decode: P = overall ^ bit 0; S=0,P=0 -> no error; P=1,S=0 -> single, pos 0; P=1, 0<S<CW -> single, pos S; P=0,S!=0 or P=1,S>=CW -> double, no correction.
REQ-023 Latency: ready_out high exactly CW+1 cycles after the start-accept edge, with all outputs valid the same cycle.
REQ-024 DONE: outputs and ready_out held; start=0 -> IDLE; held start never re-triggers.
REQ-025 IDLE keeps last results and ready_out=1 until next accepted start.
REQ-026 start during LOAD/SCAN/FINISH/DONE ignored.
REQ-027 Arithmetic: syndrome PW bits, iterator SW bits, no wrap beyond CW-1.

Reset
REQ-028 reset, any state incl. mid-SCAN: -> IDLE next edge; busy_out, ready_out, error flags, err_pos_out, code_out, data_out all 0; operation discarded.
REQ-029 reset dominates start on the same edge.

Configuration
REQ-030 Macro HAMMING_CORRECT_EN defined: single error flips bit err_pos_out in code_out; data_out extracted from corrected word.
REQ-031 Macro undefined: detect-only; code_out = code_in, data_out from uncorrected word; flags and err_pos_out unchanged in meaning.

Verification (DW=11, PW=4)
REQ-032 Encode data_in=11'h001 -> code_out=16'h000F, flags 0, ready_out at cycle 17 after accept.
REQ-033 Decode 16'h000F -> data_out=11'h001, err_single_out=0, err_double_out=0.
REQ-034 Decode 16'h002F -> err_single_out=1, err_pos_out=5, code_out=16'h000F, data_out=11'h001 (CORRECT_EN); code_out=16'h002F without it.
REQ-035 Decode 16'h000E -> err_single_out=1, err_pos_out=0, data_out=11'h001; decode 16'h003F -> err_double_out=1, err_pos_out=0.
REQ-036 reset at SCAN cycle 6 -> all outputs 0 next cycle; fresh encode of 11'h001 then yields 16'h000F.
REQ-037 start held high through DONE -> single operation only; DW=8, PW=4 decode with S=15, P=1 -> err_double_out=1.
